// File: rtl/e_mdu_if.sv
// Execute-stage MDU bus.
// master: pipeline side (drives Req/op/A/B, observes start/busy/HI/LO/MDUout).
// slave : MDU side.
interface e_mdu_if;
  logic        Req;     // flush of the instruction currently in E
  logic [3:0]  op;      // MDU operation code
  logic [31:0] A;       // rs operand
  logic [31:0] B;       // rt operand
  logic        start;   // combinational: new multi-cycle op accepted this cycle
  logic        busy;    // registered: operation in flight
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDUout;  // mfhi/mflo read data

  modport master (
    output Req, op, A, B,
    input  start, busy, HI, LO, MDUout
  );

  modport slave (
    input  Req, op, A, B,
    output start, busy, HI, LO, MDUout
  );
endinterface

// File: rtl/e_mdu.sv
// Multiply/divide unit for the execute stage.
// Owns HI/LO and runs mult/multu/div/divu as fixed-latency multi-cycle operations.
// Ports:
//   clk   - clock, all state updates on the rising edge
//   reset - synchronous, active-high reset
//   bus   - e_mdu_if slave modport (Req/op/A/B in; start/busy/HI/LO/MDUout out)
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic    clk,
  input logic    reset,
  e_mdu_if.slave bus
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic [31:0]     pend_hi_q, pend_hi_d;
  logic [31:0]     pend_lo_q, pend_lo_d;
  logic            pend_we_q, pend_we_d;  // cleared for divide by zero: commit nothing

  logic        is_mult, is_div, start;
  logic [63:0] prod;
  logic [31:0] quot, rem;

  assign is_mult = (bus.op == 4'd1) || (bus.op == 4'd2);
  assign is_div  = (bus.op == 4'd3) || (bus.op == 4'd4);
  assign start   = (is_mult || is_div) && !bus.Req && (state_q == StIdle);

  // Arithmetic datapath, evaluated from the current operands.
  always_comb begin
    if (bus.op == 4'd1) begin
      prod = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    end else begin
      prod = {32'b0, bus.A} * {32'b0, bus.B};
    end
    quot = '0;
    rem  = '0;
    if (bus.B != 32'd0) begin
      if (bus.op == 4'd3) begin
        // The one signed overflow case is handled explicitly.
        if (bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF) begin
          quot = 32'h8000_0000;
          rem  = 32'd0;
        end else begin
          quot = $signed(bus.A) / $signed(bus.B);
          rem  = $signed(bus.A) % $signed(bus.B);
        end
      end else begin
        quot = bus.A / bus.B;
        rem  = bus.A % bus.B;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StBusy;
          cnt_d     = is_mult ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
          pend_hi_d = is_mult ? prod[63:32] : rem;
          pend_lo_d = is_mult ? prod[31:0]  : quot;
          pend_we_d = is_mult || (bus.B != 32'd0);
        end else if (!bus.Req && bus.op == 4'd7) begin
          hi_d = bus.A;
        end else if (!bus.Req && bus.op == 4'd8) begin
          lo_d = bus.A;
        end
      end
      StBusy: begin
        // Req and new ops are ignored while an operation is in flight.
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          if (pend_we_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
    end
  end

  assign bus.start  = start;
  assign bus.busy   = (state_q == StBusy);
  assign bus.HI     = hi_q;
  assign bus.LO     = lo_q;
  assign bus.MDUout = (bus.op == 4'd5) ? hi_q : (bus.op == 4'd6) ? lo_q : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu (MULT_CYCLES=5, DIV_CYCLES=10).
module tb_e_mdu;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  e_mdu_if bus_if ();

  e_mdu #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic req);
    bus_if.op  = op;
    bus_if.A   = a;
    bus_if.B   = b;
    bus_if.Req = req;
  endtask

  // Counts sampled busy cycles until busy drops (bounded).
  task automatic wait_idle(output int n);
    n = 0;
    while (bus_if.busy === 1'b1 && n < 40) begin
      n++;
      cyc();
    end
  endtask

  task automatic test_reset();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    total++; if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", bus_if.busy); end
    total++; if (bus_if.HI !== 32'd0) begin bad++; $display("FAIL reset_hi got %h want 0", bus_if.HI); end
    total++; if (bus_if.LO !== 32'd0) begin bad++; $display("FAIL reset_lo got %h want 0", bus_if.LO); end
    total++; if (bus_if.start !== 1'b0) begin bad++; $display("FAIL reset_start got %b want 0", bus_if.start); end
  endtask

  task automatic test_multu();
    int n;
    drive(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    #1;
    total++; if (bus_if.start !== 1'b1) begin bad++; $display("FAIL multu_start got %b want 1", bus_if.start); end
    cyc();
    // op still presented: busy must mask start
    total++; if (bus_if.start !== 1'b0) begin bad++; $display("FAIL multu_start_busy got %b want 0", bus_if.start); end
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    wait_idle(n);
    total++; if (n !== 5) begin bad++; $display("FAIL multu_busy_cycles got %0d want 5", n); end
    total++; if (bus_if.HI !== 32'h0000_0001) begin bad++; $display("FAIL multu_hi got %h want 00000001", bus_if.HI); end
    total++; if (bus_if.LO !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_lo got %h want fffffffe", bus_if.LO); end
  endtask

  task automatic test_mult();
    int n;
    drive(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    cyc();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    wait_idle(n);
    total++; if (n !== 5) begin bad++; $display("FAIL mult_busy_cycles got %0d want 5", n); end
    total++; if (bus_if.HI !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got %h want ffffffff", bus_if.HI); end
    total++; if (bus_if.LO !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mult_lo got %h want fffffffe", bus_if.LO); end
  endtask

  task automatic test_div();
    int n;
    drive(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    cyc();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    wait_idle(n);
    total++; if (n !== 10) begin bad++; $display("FAIL div_busy_cycles got %0d want 10", n); end
    total++; if (bus_if.LO !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_neg_lo got %h want fffffffd", bus_if.LO); end
    total++; if (bus_if.HI !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_neg_hi got %h want ffffffff", bus_if.HI); end
    drive(4'd4, 32'd7, 32'd2, 1'b0);
    cyc();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    wait_idle(n);
    total++; if (bus_if.LO !== 32'd3) begin bad++; $display("FAIL divu_lo got %h want 00000003", bus_if.LO); end
    total++; if (bus_if.HI !== 32'd1) begin bad++; $display("FAIL divu_hi got %h want 00000001", bus_if.HI); end
    drive(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    cyc();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    wait_idle(n);
    total++; if (bus_if.LO !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf_lo got %h want 80000000", bus_if.LO); end
    total++; if (bus_if.HI !== 32'd0) begin bad++; $display("FAIL div_ovf_hi got %h want 00000000", bus_if.HI); end
  endtask

  task automatic test_div_zero();
    int n;
    drive(4'd7, 32'h0000_1234, 32'd0, 1'b0);
    cyc();
    drive(4'd5, 32'd0, 32'd0, 1'b0);
    #1;
    total++; if (bus_if.MDUout !== 32'h1234) begin bad++; $display("FAIL mthi_visible got %h want 00001234", bus_if.MDUout); end
    drive(4'd8, 32'h0000_5678, 32'd0, 1'b0);
    cyc();
    total++; if (bus_if.LO !== 32'h5678) begin bad++; $display("FAIL mtlo_lo got %h want 00005678", bus_if.LO); end
    drive(4'd4, 32'd99, 32'd0, 1'b0);
    cyc();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    wait_idle(n);
    total++; if (n !== 10) begin bad++; $display("FAIL divz_busy_cycles got %0d want 10", n); end
    total++; if (bus_if.HI !== 32'h1234) begin bad++; $display("FAIL divz_hi got %h want 00001234", bus_if.HI); end
    total++; if (bus_if.LO !== 32'h5678) begin bad++; $display("FAIL divz_lo got %h want 00005678", bus_if.LO); end
    drive(4'd5, 32'd0, 32'd0, 1'b0);
    #1;
    total++; if (bus_if.MDUout !== 32'h1234) begin bad++; $display("FAIL mfhi got %h want 00001234", bus_if.MDUout); end
    drive(4'd6, 32'd0, 32'd0, 1'b0);
    #1;
    total++; if (bus_if.MDUout !== 32'h5678) begin bad++; $display("FAIL mflo got %h want 00005678", bus_if.MDUout); end
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    #1;
    total++; if (bus_if.MDUout !== 32'd0) begin bad++; $display("FAIL mdu_out_none got %h want 0", bus_if.MDUout); end
  endtask

  task automatic test_flush();
    int n;
    drive(4'd1, 32'd3, 32'd3, 1'b1);
    #1;
    total++; if (bus_if.start !== 1'b0) begin bad++; $display("FAIL flush_start got %b want 0", bus_if.start); end
    cyc();
    total++; if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL flush_busy got %b want 0", bus_if.busy); end
    total++; if (bus_if.LO !== 32'h5678) begin bad++; $display("FAIL flush_lo got %h want 00005678", bus_if.LO); end
    drive(4'd7, 32'hDEAD_BEEF, 32'd0, 1'b1);
    cyc();
    total++; if (bus_if.HI !== 32'h1234) begin bad++; $display("FAIL flush_mthi got %h want 00001234", bus_if.HI); end
    // div 100/7 with Req raised in its third busy cycle
    drive(4'd3, 32'd100, 32'd7, 1'b0);
    cyc();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    cyc();
    cyc();
    drive(4'd0, 32'd0, 32'd0, 1'b1);
    total++; if (bus_if.busy !== 1'b1) begin bad++; $display("FAIL flush_div_busy got %b want 1", bus_if.busy); end
    cyc();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    wait_idle(n);
    total++; if (n !== 7) begin bad++; $display("FAIL flush_div_remaining got %0d want 7", n); end
    total++; if (bus_if.LO !== 32'd14) begin bad++; $display("FAIL flush_div_lo got %h want 0000000e", bus_if.LO); end
    total++; if (bus_if.HI !== 32'd2) begin bad++; $display("FAIL flush_div_hi got %h want 00000002", bus_if.HI); end
  endtask

  task automatic test_back_to_back();
    int n;
    drive(4'd3, 32'd20, 32'd3, 1'b0);
    cyc();
    drive(4'd3, 32'd9, 32'd9, 1'b0);
    #1;
    total++; if (bus_if.start !== 1'b0) begin bad++; $display("FAIL b2b_ignored_start got %b want 0", bus_if.start); end
    cyc();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    wait_idle(n);
    total++; if (n !== 9) begin bad++; $display("FAIL b2b_div_remaining got %0d want 9", n); end
    total++; if (bus_if.LO !== 32'd6) begin bad++; $display("FAIL b2b_div_lo got %h want 00000006", bus_if.LO); end
    total++; if (bus_if.HI !== 32'd2) begin bad++; $display("FAIL b2b_div_hi got %h want 00000002", bus_if.HI); end
    // mult held on the bus: the second one starts in the first idle cycle
    drive(4'd1, 32'd3, 32'd4, 1'b0);
    cyc();
    drive(4'd1, 32'd5, 32'd6, 1'b0);
    wait_idle(n);
    total++; if (n !== 5) begin bad++; $display("FAIL b2b_mult_cycles got %0d want 5", n); end
    total++; if (bus_if.start !== 1'b1) begin bad++; $display("FAIL b2b_restart got %b want 1", bus_if.start); end
    total++; if (bus_if.LO !== 32'd12) begin bad++; $display("FAIL b2b_mult1_lo got %h want 0000000c", bus_if.LO); end
    cyc();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    total++; if (bus_if.busy !== 1'b1) begin bad++; $display("FAIL b2b_mult2_busy got %b want 1", bus_if.busy); end
    wait_idle(n);
    total++; if (bus_if.LO !== 32'd30) begin bad++; $display("FAIL b2b_mult2_lo got %h want 0000001e", bus_if.LO); end
    total++; if (bus_if.HI !== 32'd0) begin bad++; $display("FAIL b2b_mult2_hi got %h want 00000000", bus_if.HI); end
  endtask

  task automatic test_reset_mid();
    drive(4'd1, 32'd7, 32'd7, 1'b0);
    cyc();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    total++; if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got %b want 0", bus_if.busy); end
    total++; if (bus_if.HI !== 32'd0) begin bad++; $display("FAIL rstmid_hi got %h want 0", bus_if.HI); end
    total++; if (bus_if.LO !== 32'd0) begin bad++; $display("FAIL rstmid_lo got %h want 0", bus_if.LO); end
    for (int i = 0; i < 8; i++) cyc();
    total++; if (bus_if.LO !== 32'd0) begin bad++; $display("FAIL rstmid_no_commit got %h want 0", bus_if.LO); end
    total++; if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy_late got %b want 0", bus_if.busy); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    #1;
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_zero();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Multiply/divide unit for the execute stage of the exception-capable pipeline. It consumes the instruction, operands and flush request latched by the ID/EX register. It owns the HI/LO architectural registers and runs mult/multu/div/divu as multi-cycle operations. It exposes `busy`/`start` so hazard logic can stall D on any MDU-class instruction.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles for mult/multu (≥1).
- `DIV_CYCLES`, 10: busy cycles for div/divu (≥1).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Req`  in  1  exception/interrupt flush of the instruction currently in E; suppresses every state-changing op this cycle.
- `op`  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9–15 treated as none.
- `A`  in  32  rs operand.
- `B`  in  32  rt operand.
- `start`  out  1  combinational: op∈{1..4} & !Req & !busy.
- `busy`  out  1  registered: operation in flight.
- `HI`  out  32  registered HI.
- `LO`  out  32  registered LO.
- `MDUout`  out  32  combinational: HI when op=5, LO when op=6, else 0.

## Operation
- State: `busy`, cycle counter (width ≥ clog2(DIV_CYCLES+1)), pending op class, pending HI/LO results, `HI`, `LO`.
- IDLE (busy=0):
  - `start`=1 → compute results from A/B this edge, store as pending, load counter with MULT_CYCLES or DIV_CYCLES, set busy.
  - op=7 & !Req → HI←A.
  - op=8 & !Req → LO←A.
  - Req=1 → no state changes at all.
- BUSY: counter decrements each edge. On the edge where the counter goes 1→0, commit pending to HI/LO and clear busy.
  - While busy, ops 1–4, 7 and 8 are ignored regardless of Req. Hazard logic must stall them, so this case is illegal but defined.
  - Req does not abort an in-flight operation.
- mult: {HI,LO} = signed(A)×signed(B), full 64-bit.
- multu: {HI,LO} = unsigned 64-bit product.
- div: LO = quotient truncated toward zero; HI = remainder with the sign of A. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient/remainder.
- Divide by zero: the operation still occupies DIV_CYCLES busy cycles. HI/LO are left unchanged at commit.
- mfhi/mflo read the current registered HI/LO. No bypass of an in-flight result; hazard logic stalls them while start|busy.

## Timing
- Reset (clk edge with reset=1): busy=0, counter=0, HI=0, LO=0, pending cleared. Reset overrides start and mthi/mtlo in the same cycle.
- Reset mid-operation: the operation is aborted and HI/LO become 0.
- Start sampled at edge T.
  - busy=1 during cycles T+1 … T+N, where N=MULT_CYCLES or DIV_CYCLES.
  - HI/LO carry the new value and busy=0 from cycle T+N+1.
- A stall predicate of start|busy covers cycle T and cycles T+1…T+N.
- A new start is accepted in the first cycle with busy=0, so operations run back-to-back with no gap cycle.
- mthi/mtlo at edge T: the new value is visible on HI/LO and MDUout from cycle T+1.
- `start` and `MDUout` are combinational with zero latency. `busy`, `HI` and `LO` are registered only.

## Test plan
- Reset then multu, A=0xFFFFFFFF, B=2:
  - start=1 for one cycle, busy=1 for exactly 5 cycles.
  - Then HI=0x00000001, LO=0xFFFFFFFE.
- mult with the same operands → HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- Signed division:
  - div A=0xFFFFFFF9 (−7), B=2 → busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu A=7, B=2 → LO=3, HI=1.
  - div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: after mthi 0x1234 and mtlo 0x5678, divu B=0.
  - busy for 10 cycles, HI/LO stay 0x1234/0x5678.
  - mfhi and mflo return 0x1234 and 0x5678 on MDUout.
- Flush interactions:
  - mult with Req=1 → start=0, busy stays 0, HI/LO unchanged.
  - mthi with Req=1 → HI unchanged.
  - Req asserted during cycle 3 of a div → the div still completes and commits.
- Boundary cases:
  - A second div presented while busy is ignored, and the first result commits.
  - A new mult in the cycle busy falls starts immediately.
  - reset asserted in cycle 2 of a mult → busy=0, HI=LO=0 on the next cycle, no later commit.
